// File: rtl/rr_mux_buf_pkg.sv
// Shared definitions for the round-robin / explicit-select output-buffered mux.
package mux_pkg;

   typedef enum logic {
      MODE_SEL = 1'b0,
      MODE_RR  = 1'b1
   } mux_mode_t;

   // Pointer increment that wraps to zero after the last channel.
   function automatic int ptr_inc(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_mux_buf_rr_pick.sv
// Rotating priority encoder: first requester at or after ptr, wrapping modulo N_CH.
module rr_pick #(
   parameter int N_CH  = 16,
   parameter int SEL_W = 4
) (
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             gnt_vld
);

   // Scan from the farthest offset back to ptr so the nearest requester is written last and wins.
   always_comb begin
      logic [SEL_W-1:0] idx;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         idx = SEL_W'((32'(ptr) + k) % N_CH);
         if (req[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = idx;
         end
      end
   end

endmodule

// File: rtl/rr_mux_buf.sv
// N-channel mux with a single registered, valid/ready output stage and a
// choice of explicit-select or round-robin arbitration.
module rr_mux_buf
   import mux_pkg::*;
#(
   parameter  int N_CH  = 16,
   parameter  int W     = 3,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode,
   input  logic [SEL_W-1:0]  sel,
   input  logic [N_CH-1:0]   in_valid,
   input  logic [N_CH*W-1:0] in_data,
   output logic [N_CH-1:0]   in_ready,
   output logic              out_valid,
   output logic [W-1:0]      out_data,
   output logic [SEL_W-1:0]  out_ch,
   input  logic              out_ready
);

   mux_mode_t        mode_m;
   logic             sel_ok;
   logic [SEL_W-1:0] sel_idx;
   logic [SEL_W-1:0] rr_idx;
   logic             rr_vld;
   logic [SEL_W-1:0] grant;
   logic             grant_vld;
   logic             can_load;
   logic             load;
   logic [W-1:0]     ch_data [N_CH];

   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     out_data_q,  out_data_d;
   logic [SEL_W-1:0] out_ch_q,    out_ch_d;
   logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

   assign mode_m = mux_mode_t'(mode);

   // An out-of-range select is steered to channel 0 for the lookup but never grants.
   assign sel_ok  = (32'(sel) < N_CH);
   assign sel_idx = sel_ok ? sel : '0;

   rr_pick #(
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
   ) u_pick (
      .req     (in_valid),
      .ptr     (rr_ptr_q),
      .gnt_idx (rr_idx),
      .gnt_vld (rr_vld)
   );

   // Choose the winning channel according to the current mode.
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      if (mode_m == MODE_SEL) begin
         grant     = sel_idx;
         grant_vld = sel_ok && in_valid[sel_idx];
      end else begin
         grant     = rr_idx;
         grant_vld = rr_vld;
      end
   end

   // A word may enter whenever the register is empty or being drained this cycle.
   assign can_load = !out_valid_q || out_ready;
   assign load     = !rst && grant_vld && can_load;

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         assign ch_data[gi]  = in_data[gi*W +: W];
         assign in_ready[gi] = load && (grant == SEL_W'(gi));
      end
   endgenerate

   // Next state of the output register and the round-robin pointer.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      rr_ptr_d    = rr_ptr_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = ch_data[grant];
         out_ch_d    = grant;
         if (mode_m == MODE_RR) begin
            rr_ptr_d = SEL_W'(ptr_inc(32'(grant), N_CH));
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_mux_buf.sv
// Randomised and directed bench for rr_mux_buf against a queue-free behavioural model.
module tb_rr_mux_buf;

   logic        clk = 1'b0;
   logic        rst;
   logic        mode;
   logic [3:0]  sel;
   logic [15:0] in_valid;
   logic [47:0] in_data;
   logic [15:0] in_ready;
   logic        out_valid;
   logic [2:0]  out_data;
   logic [3:0]  out_ch;
   logic        out_ready;

   logic        mode10;
   logic [3:0]  sel10;
   logic [9:0]  in_valid10;
   logic [29:0] in_data10;
   logic [9:0]  in_ready10;
   logic        out_valid10;
   logic [2:0]  out_data10;
   logic [3:0]  out_ch10;
   logic        out_ready10;

   int errors = 0;
   int checks = 0;

   // behavioural model of the 16-channel instance
   bit          m_valid;
   logic [2:0]  m_data;
   logic [3:0]  m_ch;
   int          m_ptr;
   logic [15:0] exp_ready;
   int          p_g;

   always #5 clk = ~clk;

   rr_mux_buf #(.N_CH(16), .W(3)) dut (
      .clk(clk), .rst(rst), .mode(mode), .sel(sel),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
      .out_ready(out_ready)
   );

   rr_mux_buf #(.N_CH(10), .W(3)) dut10 (
      .clk(clk), .rst(rst), .mode(mode10), .sel(sel10),
      .in_valid(in_valid10), .in_data(in_data10), .in_ready(in_ready10),
      .out_valid(out_valid10), .out_data(out_data10), .out_ch(out_ch10),
      .out_ready(out_ready10)
   );

   // Settle inputs and work out which channel should be accepted this cycle.
   task automatic predict();
      bit can_load;
      bit gv;
      #1;
      can_load = !m_valid || out_ready;
      gv  = 1'b0;
      p_g = 0;
      if (mode == 1'b0) begin
         p_g = int'(sel);
         gv  = in_valid[p_g];
      end else begin
         for (int k = 0; k < 16; k++) begin
            int c;
            c = (m_ptr + k) % 16;
            if (!gv && in_valid[c]) begin
               gv  = 1'b1;
               p_g = c;
            end
         end
      end
      exp_ready = (!rst && gv && can_load) ? (16'd1 << p_g) : 16'd0;
   endtask

   // Advance the model across one rising edge and step just past it.
   task automatic commit();
      @(posedge clk);
      if (rst) begin
         m_valid = 1'b0; m_data = '0; m_ch = '0; m_ptr = 0;
      end else if (exp_ready != 16'd0) begin
         m_valid = 1'b1;
         m_data  = in_data[p_g*3 +: 3];
         m_ch    = 4'(p_g);
         if (mode == 1'b1) m_ptr = (p_g + 1) % 16;
         $display("xfer mode=%0d ch=%0d data=%0d", mode, p_g, m_data);
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; mode = 1'b1; sel = '0; in_valid = 16'hFFFF;
      in_data = 48'({$urandom(), $urandom()}); out_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         predict();
         checks++;
         if (in_ready !== 16'h0000) begin
            errors++; $display("FAIL reset_in_ready got=%h want=0000", in_ready);
         end
         commit();
      end
      checks++;
      if ({out_valid, out_data, out_ch} !== 8'h00) begin
         errors++; $display("FAIL reset_outputs got v=%b d=%0d ch=%0d want 0/0/0", out_valid, out_data, out_ch);
      end
      rst = 1'b0;
      predict();
      checks++;
      if (in_ready !== 16'h0001) begin
         errors++; $display("FAIL reset_first_rr_ready got=%h want=0001", in_ready);
      end
      commit();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 4'd0) begin
         errors++; $display("FAIL reset_first_rr got v=%b ch=%0d want 1/0", out_valid, out_ch);
      end
   endtask

   task automatic test_sel();
      mode = 1'b0; sel = 4'd5; in_valid = 16'hFFFF; out_ready = 1'b1;
      in_data = 48'({$urandom(), $urandom()});
      in_data[15 +: 3] = 3'b101;
      predict();
      checks++;
      if (in_ready !== 16'h0020) begin
         errors++; $display("FAIL sel5_ready got=%h want=0020", in_ready);
      end
      commit();
      checks++;
      if ({out_valid, out_data, out_ch} !== {1'b1, 3'b101, 4'd5}) begin
         errors++; $display("FAIL sel5_out got v=%b d=%0d ch=%0d want 1/5/5", out_valid, out_data, out_ch);
      end
   endtask

   task automatic test_rr_wrap();
      int seq [5] = '{2, 7, 15, 2, 7};
      mode = 1'b1; in_valid = 16'h8084; out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_data = 48'({$urandom(), $urandom()});
         predict();
         checks++;
         if (in_ready !== exp_ready) begin
            errors++; $display("FAIL rr_wrap_ready[%0d] got=%h want=%h", k, in_ready, exp_ready);
         end
         commit();
         checks++;
         if (out_valid !== 1'b1 || out_ch !== 4'(seq[k]) || out_data !== m_data) begin
            errors++; $display("FAIL rr_wrap_out[%0d] got v=%b ch=%0d d=%0d want 1/%0d/%0d", k, out_valid, out_ch, out_data, seq[k], m_data);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [2:0] held;
      mode = 1'b1; in_valid = 16'h8084; out_ready = 1'b1;
      in_data = 48'({$urandom(), $urandom()});
      predict();
      commit();
      checks++;
      if (out_ch !== 4'd15) begin
         errors++; $display("FAIL bp_load got ch=%0d want 15", out_ch);
      end
      held = in_data[45 +: 3];
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         predict();
         checks++;
         if (in_ready !== 16'h0000) begin
            errors++; $display("FAIL bp_ready[%0d] got=%h want=0000", c, in_ready);
         end
         commit();
         checks++;
         if ({out_valid, out_data, out_ch} !== {1'b1, held, 4'd15}) begin
            errors++; $display("FAIL bp_hold[%0d] got v=%b d=%0d ch=%0d want 1/%0d/15", c, out_valid, out_data, out_ch, held);
         end
      end
      out_ready = 1'b1;
      predict();
      checks++;
      if (in_ready !== 16'h0004) begin
         errors++; $display("FAIL bp_release_ready got=%h want=0004", in_ready);
      end
      commit();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 4'd2 || out_data !== in_data[6 +: 3]) begin
         errors++; $display("FAIL bp_release got v=%b ch=%0d d=%0d want 1/2/%0d", out_valid, out_ch, out_data, in_data[6 +: 3]);
      end
   endtask

   task automatic test_mode_switch();
      int want [4] = '{3, 0, 0, 5};
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_data = 48'({$urandom(), $urandom()});
         case (k)
            0:       begin mode = 1'b1; in_valid = 16'h0008; end
            1, 2:    begin mode = 1'b0; sel = 4'd0; in_valid = 16'h0001; end
            default: begin mode = 1'b1; in_valid = 16'h0022; end
         endcase
         predict();
         checks++;
         if (in_ready !== exp_ready) begin
            errors++; $display("FAIL mode_sw_ready[%0d] got=%h want=%h", k, in_ready, exp_ready);
         end
         commit();
         checks++;
         if (out_valid !== 1'b1 || out_ch !== 4'(want[k])) begin
            errors++; $display("FAIL mode_sw_out[%0d] got v=%b ch=%0d want 1/%0d", k, out_valid, out_ch, want[k]);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst       = ($urandom_range(0, 40) == 0);
         mode      = 1'($urandom());
         sel       = 4'($urandom());
         in_valid  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom() & $urandom());
         in_data   = 48'({$urandom(), $urandom()});
         out_ready = ($urandom_range(0, 3) != 0);
         predict();
         checks++;
         if (in_ready !== exp_ready) begin
            errors++; $display("FAIL rand_ready[%0d] got=%h want=%h", c, in_ready, exp_ready);
         end
         commit();
         checks++;
         if ({out_valid, out_data, out_ch} !== {m_valid, m_data, m_ch}) begin
            errors++; $display("FAIL rand_out[%0d] got v=%b d=%0d ch=%0d want %b/%0d/%0d", c, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_nch10();
      mode10 = 1'b0; sel10 = 4'd12; in_valid10 = 10'h3FF; out_ready10 = 1'b1;
      in_data10 = 30'($urandom());
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (in_ready10 !== 10'h000) begin
            errors++; $display("FAIL n10_sel12_ready[%0d] got=%h want=000", c, in_ready10);
         end
         @(posedge clk); #1;
         checks++;
         if (out_valid10 !== 1'b0) begin
            errors++; $display("FAIL n10_sel12_valid[%0d] got=%b want=0", c, out_valid10);
         end
      end
      sel10 = 4'd9;
      #1;
      checks++;
      if (in_ready10 !== 10'h200) begin
         errors++; $display("FAIL n10_sel9_ready got=%h want=200", in_ready10);
      end
      @(posedge clk); #1;
      $display("xfer n10 ch=%0d data=%0d", out_ch10, out_data10);
      checks++;
      if ({out_valid10, out_data10, out_ch10} !== {1'b1, in_data10[27 +: 3], 4'd9}) begin
         errors++; $display("FAIL n10_sel9_out got v=%b d=%0d ch=%0d want 1/%0d/9", out_valid10, out_data10, out_ch10, in_data10[27 +: 3]);
      end
   endtask

   initial begin
      m_valid = 1'b0; m_data = '0; m_ch = '0; m_ptr = 0; exp_ready = '0; p_g = 0;
      mode10 = 1'b0; sel10 = '0; in_valid10 = '0; in_data10 = '0; out_ready10 = 1'b1;
      test_reset();
      test_sel();
      test_rr_wrap();
      test_backpressure();
      test_mode_switch();
      test_random();
      test_nch10();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
